// File: rtl/bus_rr_interconnect_pkg.sv
// Shared definitions for the round-robin bus interconnect: FSM encoding,
// default slave-select width and the address-to-slave decode helper.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } bus_state_e;

  localparam int DEVICE_BIT_WIDTH_DEFAULT = 2;

  // Slave index is the top dev_w bits of an addr_w-bit address.
  function automatic int unsigned slave_index(input logic [63:0] addr,
                                              input int          addr_w,
                                              input int          dev_w);
    return 32'((addr >> (addr_w - dev_w)) & ((64'd1 << dev_w) - 64'd1));
  endfunction

endpackage

// File: rtl/bus_rr_interconnect_if.sv
// Bundle of master-side and slave-side bus signals of the shared interconnect,
// with views for masters, slaves and the interconnect fabric itself.
interface bus_rr_interconnect_if #(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = 3,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32
);
  logic [NUM_MASTERS-1:0]            m_breq;
  logic [NUM_MASTERS-1:0]            m_bgrant;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]            m_wen;
  logic [NUM_MASTERS-1:0]            m_ren;
  logic [DATA_WIDTH-1:0]             m_rdata;
  logic [NUM_MASTERS-1:0]            m_ack;
  logic                              m_err;

  logic [ADDR_WIDTH-1:0]             s_addr;
  logic [DATA_WIDTH-1:0]             s_wdata;
  logic [NUM_SLAVES-1:0]             s_wen;
  logic [NUM_SLAVES-1:0]             s_ren;
  logic [NUM_SLAVES*DATA_WIDTH-1:0]  s_rdata;
  logic [NUM_SLAVES-1:0]             s_ready;

  modport master (
    output m_breq, m_addr, m_wdata, m_wen, m_ren,
    input  m_bgrant, m_rdata, m_ack, m_err
  );

  modport slave (
    input  s_addr, s_wdata, s_wen, s_ren,
    output s_rdata, s_ready
  );

  modport fabric (
    input  m_breq, m_addr, m_wdata, m_wen, m_ren, s_rdata, s_ready,
    output m_bgrant, m_rdata, m_ack, m_err, s_addr, s_wdata, s_wen, s_ren
  );

endinterface

// File: rtl/bus_rr_interconnect_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester above
// last_grant, wrapping modulo N. Output is registered by the caller.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  always_comb begin
    int   cand;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last_grant) + k) % N;
      if (enable && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/bus_rr_interconnect.sv
// Shared-bus interconnect: round-robin arbitration among masters, one
// registered transaction at a time, with decode and timeout error responses.
module bus_rr_interconnect
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS      = 4,
  parameter int NUM_SLAVES       = 3,
  parameter int ADDR_WIDTH       = 16,
  parameter int DATA_WIDTH       = 32,
  parameter int DEVICE_BIT_WIDTH = DEVICE_BIT_WIDTH_DEFAULT,
  parameter int TIMEOUT_CYCLES   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  bus_rr_interconnect_if.fabric bus
);

  localparam int MIW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES) + 1;

  bus_state_e                  state_q, state_d;
  logic [MIW-1:0]              last_q, last_d;
  logic [MIW-1:0]              owner_q, owner_d;
  logic [NUM_MASTERS-1:0]      grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;
  logic                        wr_q, wr_d;
  logic                        err_q, err_d;
  logic [DEVICE_BIT_WIDTH-1:0] sidx_q, sidx_d;
  logic [TW-1:0]               tcnt_q, tcnt_d;

  logic [NUM_MASTERS-1:0]      arb_grant;
  logic [MIW-1:0]              arb_idx;

  logic                        own_breq, own_wen, own_ren;
  logic [ADDR_WIDTH-1:0]       own_addr;
  logic [DATA_WIDTH-1:0]       own_wdata;
  int unsigned                 dec_idx;
  logic                        dec_ok;
  logic                        sel_ready;
  logic [DATA_WIDTH-1:0]       sel_rdata;

  rr_arbiter #(.N(NUM_MASTERS), .IW(MIW)) u_arb (
    .req        (bus.m_breq),
    .last_grant (last_q),
    .enable     (state_q == IDLE),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  // Current owner's request and the selected slave's response
  always_comb begin
    own_breq  = bus.m_breq[owner_q];
    own_wen   = bus.m_wen[owner_q];
    own_ren   = bus.m_ren[owner_q];
    own_addr  = bus.m_addr[int'(owner_q)*ADDR_WIDTH +: ADDR_WIDTH];
    own_wdata = bus.m_wdata[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
    dec_idx   = slave_index(64'(own_addr), ADDR_WIDTH, DEVICE_BIT_WIDTH);
    dec_ok    = dec_idx < 32'(NUM_SLAVES);
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      if (int'(sidx_q) == s) begin
        sel_ready = bus.s_ready[s];
        sel_rdata = bus.s_rdata[s*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    err_d   = err_q;
    sidx_d  = sidx_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      IDLE: begin
        if (|bus.m_breq) begin
          owner_d = arb_idx;
          grant_d = arb_grant;
          err_d   = 1'b0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (own_wen && own_ren) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (own_wen || own_ren) begin
          if (dec_ok) begin
            addr_d  = own_addr;
            wdata_d = own_wdata;
            wr_d    = own_wen;
            sidx_d  = DEVICE_BIT_WIDTH'(dec_idx);
            tcnt_d  = '0;
            state_d = ACCESS;
          end else begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end else if (!own_breq) begin
          last_d  = owner_q;
          grant_d = '0;
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          if (!wr_q) rdata_d = sel_rdata;
          state_d = RESP;
        end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      RESP: begin
        last_d  = owner_q;
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Every output is derived from these registers, so reset clears them all.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= MIW'(NUM_MASTERS - 1);
      owner_q <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      sidx_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      sidx_q  <= sidx_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    bus.s_wen = '0;
    bus.s_ren = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      if (state_q == ACCESS && int'(sidx_q) == s) begin
        bus.s_wen[s] = wr_q;
        bus.s_ren[s] = !wr_q;
      end
    end
  end

  assign bus.m_bgrant = grant_q;
  assign bus.m_ack    = (state_q == RESP) ? grant_q : '0;
  assign bus.m_err    = (state_q == RESP) && err_q;
  assign bus.m_rdata  = rdata_q;
  assign bus.s_addr   = addr_q;
  assign bus.s_wdata  = wdata_q;

endmodule
